// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register-file write port, with a one-entry write stage, read forwarding and x0 write suppression
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int ZERO_GUARD = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic [2:0]         grant_id,
  input  logic [AW-1:0]      rd_addr1,
  input  logic [AW-1:0]      rd_addr2,
  output logic               fwd_hit1,
  output logic               fwd_hit2,
  output logic [DW-1:0]      fwd_data,
  output logic [15:0]        drop_cnt
);
  logic [2:0] ptr;
  logic [2:0] win;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic found;
  logic drop;
  int best_d;
  int d;
  always_comb begin
    best_d = NREQ;
    d = 0;
    win = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - int'(ptr) + NREQ) % NREQ;
      if (req_valid[i] && d < best_d) begin
        best_d = d;
        win = 3'(i);
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end
  assign found = best_d < NREQ;
  assign drop = found && ZERO_GUARD != 0 && sel_addr == '0;
  assign req_ready = (found && rstn) ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;
  assign fwd_hit1 = wr_en && wr_addr == rd_addr1;
  assign fwd_hit2 = wr_en && wr_addr == rd_addr2;
  assign fwd_data = wr_data;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      grant_id <= '0;
      drop_cnt <= '0;
      ptr <= '0;
    end else begin
      wr_en <= found && !drop;
      if (found) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
        grant_id <= win;
        ptr <= (win == 3'(NREQ-1)) ? '0 : win + 3'd1;
      end
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rstn;
  logic [NREQ-1:0] req_valid;
  logic [AW-1:0] a [NREQ];
  logic [DW-1:0] dat [NREQ];
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic [NREQ-1:0] req_ready, u_ready;
  logic wr_en, u_wr_en, fwd_hit1, fwd_hit2, u_hit1, u_hit2;
  logic [AW-1:0] wr_addr, u_addr;
  logic [DW-1:0] wr_data, fwd_data, u_data, u_fwd;
  logic [2:0] grant_id, u_gid;
  logic [15:0] drop_cnt, u_drop;
  int n_checks = 0;
  int n_errors = 0;
  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {dat[2], dat[1], dat[0]};
  always #5 clk = ~clk;
  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_GUARD(1)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .grant_id(grant_id),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data(fwd_data), .drop_cnt(drop_cnt)
  );
  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_GUARD(0)) dut_ng (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(u_ready), .wr_en(u_wr_en), .wr_addr(u_addr), .wr_data(u_data), .grant_id(u_gid),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .fwd_hit1(u_hit1), .fwd_hit2(u_hit2),
    .fwd_data(u_fwd), .drop_cnt(u_drop)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rstn = 1'b0;
    req_valid = 3'b111;
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
    dat[0] = 32'h100; dat[1] = 32'h200; dat[2] = 32'h300;
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd8;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
    end
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    rstn = 1'b1;
    #1;
    chk("first_ready", 32'(req_ready), 32'b001);
    step();
    chk("first_wr_en", 32'(wr_en), 32'd1);
    chk("first_gid", 32'(grant_id), 32'd0);
    chk("first_addr", 32'(wr_addr), 32'd1);
    req_valid = 3'b000;
    #1;
    chk("idle_ready", 32'(req_ready), 32'd0);
    step();
    chk("idle_wr_en", 32'(wr_en), 32'd0);
    chk("idle_hold_addr", 32'(wr_addr), 32'd1);
    chk("idle_hold_data", wr_data, 32'h100);
    req_valid = 3'b001;
    a[0] = 5'd5;
    dat[0] = 32'hDEADBEEF;
    #1;
    chk("single_ready", 32'(req_ready), 32'b001);
    step();
    chk("single_wr_en", 32'(wr_en), 32'd1);
    chk("single_addr", 32'(wr_addr), 32'd5);
    chk("single_data", wr_data, 32'hDEADBEEF);
    chk("single_gid", 32'(grant_id), 32'd0);
    req_valid = 3'b000;
    #1;
    chk("single_pulse", 32'(req_ready), 32'd0);
    step();
    chk("single_done", 32'(wr_en), 32'd0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    req_valid = 3'b111;
    a[0] = 5'd10; a[1] = 5'd11; a[2] = 5'd12;
    dat[0] = 32'hA0; dat[1] = 32'hA1; dat[2] = 32'hA2;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
      step();
      chk("rr_gid", 32'(grant_id), 32'(k % 3));
      chk("rr_wr_en", 32'(wr_en), 32'd1);
      chk("rr_addr", 32'(wr_addr), 32'(10 + k % 3));
      chk("rr_data", wr_data, 32'(32'hA0 + k % 3));
    end
    req_valid = 3'b000;
    step();
    req_valid = 3'b010;
    a[1] = 5'd0;
    dat[1] = 32'h55;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("x0_ready", 32'(req_ready), 32'b010);
      step();
      chk("x0_wr_en", 32'(wr_en), 32'd0);
      chk("x0_noguard_wr_en", 32'(u_wr_en), 32'd1);
      chk("x0_fwd_hit", 32'(fwd_hit1), 32'd0);
    end
    chk("x0_drop", 32'(drop_cnt), 32'd3);
    chk("x0_noguard_drop", 32'(u_drop), 32'd0);
    chk("x0_gid", 32'(grant_id), 32'd1);
    req_valid = 3'b011;
    a[0] = 5'd7;
    dat[0] = 32'h12345678;
    #1;
    chk("x0_ptr_adv", 32'(req_ready), 32'b001);
    step();
    chk("fwd_wr_en", 32'(wr_en), 32'd1);
    chk("fwd_hit1", 32'(fwd_hit1), 32'd1);
    chk("fwd_hit2", 32'(fwd_hit2), 32'd0);
    chk("fwd_data", fwd_data, 32'h12345678);
    chk("fwd_drop_hold", 32'(drop_cnt), 32'd3);
    req_valid = 3'b000;
    rd_addr2 = 5'd7;
    #1;
    chk("fwd_hit2_match", 32'(fwd_hit2), 32'd1);
    step();
    chk("fwd_gated", 32'(fwd_hit1), 32'd0);
    req_valid = 3'b001;
    a[0] = 5'd9;
    dat[0] = 32'hCAFE;
    step();
    chk("mid_wr_en", 32'(wr_en), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_ready", 32'(req_ready), 32'd0);
    step();
    chk("mid_wr_en_off", 32'(wr_en), 32'd0);
    chk("mid_drop", 32'(drop_cnt), 32'd0);
    chk("mid_addr", 32'(wr_addr), 32'd0);
    chk("mid_fwd", 32'(fwd_hit1), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
